sqrt32: RTL and testbench

- Sequential integer square root: y = floor(sqrt(x)) for a 32-bit unsigned x, giving a 16-bit root.
- One computation runs per reset release. Reset release is the start strobe; rdy flags completion.
- Used as a small iterative arithmetic unit with a bit-serial digit-by-digit algorithm, 2 radicand bits per clock.

---
 rtl/sqrt32.sv | 102 ++++++++++
 tb/tb_sqrt32.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/sqrt32.sv
// Sequential 32-bit integer square root, two radicand bits per clock; rdy rises 17 edges after reset release.
// Define SQRT32_REMAINDER_EN to add the rem output (x - y*y).
module sqrt32 (
  input  logic        clk,
  output logic        rdy,
  input  logic        reset,
  input  logic [31:0] x,
  output logic [15:0] y
`ifdef SQRT32_REMAINDER_EN
  ,
  output logic [16:0] rem
`endif
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] sh;
  logic [17:0] part;
  logic [15:0] root;
  logic [4:0]  cnt;

  logic [17:0] acc;
  logic [17:0] sub;
  logic [18:0] diff;
  logic        fit;
  logic [17:0] part_next;
  logic [15:0] root_next;
  logic        last;

  // One digit step: bring down two radicand bits and try to subtract 4*root+1.
  always_comb begin
    acc       = 18'({part, sh[31:30]});
    sub       = {root, 2'b01};
    diff      = {1'b0, acc} - {1'b0, sub};
    fit       = ~diff[18];
    part_next = fit ? diff[17:0] : acc;
    root_next = {root[14:0], fit};
    last      = (cnt == 5'd15);
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD:    state_next = CALC;
      CALC:    if (last) state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LOAD;
    else       state <= state_next;
  end

  // rdy is a level, not a handshake: once high it holds with y until the next reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh   <= 32'd0;
      part <= 18'd0;
      root <= 16'd0;
      cnt  <= 5'd0;
      rdy  <= 1'b0;
      y    <= 16'd0;
`ifdef SQRT32_REMAINDER_EN
      rem  <= 17'd0;
`endif
    end else begin
      case (state)
        LOAD: begin
          sh   <= x;
          part <= 18'd0;
          root <= 16'd0;
          cnt  <= 5'd0;
        end
        CALC: begin
          sh   <= {sh[29:0], 2'b00};
          part <= part_next;
          root <= root_next;
          cnt  <= cnt + 5'd1;
          if (last) begin
            rdy <= 1'b1;
            y   <= root_next;
`ifdef SQRT32_REMAINDER_EN
            rem <= part_next[16:0];
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt32.sv
// Self-checking bench for sqrt32: directed boundaries, latch/abort scenarios and random radicands
// checked against a real-arithmetic square-root model.
module tb_sqrt32;

  logic        clk;
  logic        reset;
  logic        rdy;
  logic [31:0] x;
  logic [15:0] y;
`ifdef SQRT32_REMAINDER_EN
  logic [16:0] rem;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];

  sqrt32 dut (
    .clk   (clk),
    .rdy   (rdy),
    .reset (reset),
    .x     (x),
    .y     (y)
`ifdef SQRT32_REMAINDER_EN
    ,
    .rem   (rem)
`endif
  );

  // Clock / reset: period 20, first rising edge at t=10.
  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Reference model: floating-point estimate corrected with exact integer bounds.
  function automatic logic [15:0] ref_sqrt(input logic [31:0] v);
    longint r;
    longint lv;
    lv = longint'(v);
    r  = longint'($floor($sqrt(real'(lv))));
    while (r * r > lv) r--;
    while ((r + 1) * (r + 1) <= lv) r++;
    return r[15:0];
  endfunction

  task automatic assert_reset();
    reset = 1'b1;
    #1;
    check("rst_rdy", rdy, 32'd0);
    check("rst_y", y, 32'd0);
`ifdef SQRT32_REMAINDER_EN
    check("rst_rem", rem, 32'd0);
`endif
  endtask

  // Expects reset already released between edges; counts 17 edges, then one hold edge.
  task automatic run_check(input logic [31:0] xl, input int change_at, input logic [31:0] xn);
    logic [15:0] e;
    longint      d;
    exp_q.push_back(ref_sqrt(xl));
    for (int i = 1; i <= 17; i++) begin
      @(posedge clk);
      #1;
      if (i == change_at) x = xn;
      if (i < 17) begin
        check("busy_rdy", rdy, 32'd0);
        check("busy_y", y, 32'd0);
      end
    end
    e = exp_q.pop_front();
    d = longint'(xl) - longint'(e) * longint'(e);
    check("done_rdy", rdy, 32'd1);
    check("root", y, 32'(e));
`ifdef SQRT32_REMAINDER_EN
    check("rem", rem, 32'(d[16:0]));
`endif
    x = $urandom;
    @(posedge clk);
    #1;
    check("hold_rdy", rdy, 32'd1);
    check("hold_y", y, 32'(e));
    if (d < 0 || d > 2 * longint'(e)) check("model_rem_range", 32'd1, 32'd0);
  endtask

  task automatic new_run(input logic [31:0] v);
    @(negedge clk);
    assert_reset();
    x = v;
    #34;
    reset = 1'b0;
    run_check(v, 0, 32'd0);
  endtask

  logic [31:0] directed [7] = '{32'd1, 32'd16, 32'd17, 32'd1000000,
                                32'hFFFF_FFFF, 32'd4294836225, 32'd4294836224};

  initial begin
    logic [31:0] n;
    reset = 1'b1;
    x     = 32'd0;
    #12;
    check("por_rdy", rdy, 32'd0);
    check("por_y", y, 32'd0);
    #23;
    reset = 1'b0;
    run_check(32'd0, 0, 32'd0);

    foreach (directed[i]) new_run(directed[i]);

    // x changes mid-computation; the LOAD-edge value must win.
    @(negedge clk);
    assert_reset();
    x = 32'd144;
    #34;
    reset = 1'b0;
    run_check(32'd144, 5, 32'd1000000);

    // Abort mid-computation, then restart with a new radicand.
    @(negedge clk);
    assert_reset();
    x = 32'd10000;
    #34;
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
    end
    assert_reset();
    x = 32'd81;
    #13;
    reset = 1'b0;
    run_check(32'd81, 0, 32'd0);

    for (int i = 0; i < 12; i++) new_run($urandom);
    for (int i = 0; i < 6; i++) begin
      n = 32'($urandom_range(1, 65535));
      new_run(n * n);
      new_run(n * n - 32'd1);
    end

    if (exp_q.size() != 0) check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
